// File: rtl/sd_cmd_host_ctrl.sv
// Host-side SD command controller.
// Builds the 40-bit command frame and hands it to the command PHY with a
// four-phase strobe/ack handshake. It then waits for the response frame or
// a timeout, latches the response and acknowledges it to the PHY.
module sd_cmd_host_ctrl #(
  parameter int CMD_W  = 40,
  parameter int RESP_W = 136
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_command,
  input  logic [31:0]       cmd_argument,
  input  logic [5:0]        cmd_index,
  input  logic              TIMEOUT_ENABLE,
  input  logic              TIMEOUT,
  input  logic              ack_in,
  input  logic              strobe_in,
  input  logic [RESP_W-1:0] cmd_in,
  output logic              strobe_out,
  output logic              ack_out,
  output logic [CMD_W-1:0]  cmd_out,
  output logic [RESP_W-9:0] response,
  output logic              cmd_complete,
  output logic              timeout_error
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND         = 3'd1,
    WAIT_ACK_LOW = 3'd2,
    WAIT_RESP    = 3'd3,
    ACK_RESP     = 3'd4,
    DONE         = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_strobe;
  logic                r_ack;
  logic [CMD_W-1:0]    r_cmd;
  logic [RESP_W-9:0]   r_resp;
  logic                r_complete;
  logic                r_to_err;

  logic                w_strobe_nxt;
  logic                w_ack_nxt;
  logic [CMD_W-1:0]    w_cmd_nxt;
  logic [RESP_W-9:0]   w_resp_nxt;
  logic                w_complete_nxt;
  logic                w_to_err_nxt;
  logic [CMD_W-1:0]    w_frame;

  // The low byte of the response frame (CRC/end bit) is not part of the payload.
  logic                w_unused_resp_tail;
  assign w_unused_resp_tail = ^cmd_in[7:0];

  // Command frame: start bit 0, transmission bit 1, index, argument (MSB first).
  assign w_frame = CMD_W'({1'b0, 1'b1, cmd_index, cmd_argument});

  assign strobe_out    = r_strobe;
  assign ack_out       = r_ack;
  assign cmd_out       = r_cmd;
  assign response      = r_resp;
  assign cmd_complete  = r_complete;
  assign timeout_error = r_to_err;

  // State and registered outputs; reset drops any in-flight handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_strobe   <= 1'b0;
      r_ack      <= 1'b0;
      r_cmd      <= '0;
      r_resp     <= '0;
      r_complete <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_strobe   <= w_strobe_nxt;
      r_ack      <= w_ack_nxt;
      r_cmd      <= w_cmd_nxt;
      r_resp     <= w_resp_nxt;
      r_complete <= w_complete_nxt;
      r_to_err   <= w_to_err_nxt;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so that every output leaves the block straight from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_strobe_nxt   = 1'b0;
    w_ack_nxt      = 1'b0;
    w_cmd_nxt      = r_cmd;
    w_resp_nxt     = r_resp;
    w_complete_nxt = 1'b0;
    w_to_err_nxt   = r_to_err;

    case (r_state)
      IDLE: begin
        if (new_command) begin
          w_cmd_nxt    = w_frame;
          w_to_err_nxt = 1'b0;
          w_strobe_nxt = 1'b1;
          w_state_nxt  = SEND;
        end
      end

      SEND: begin
        if (ack_in) begin
          w_state_nxt = WAIT_ACK_LOW;
        end else begin
          w_strobe_nxt = 1'b1;
        end
      end

      WAIT_ACK_LOW: begin
        if (!ack_in) begin
          w_state_nxt = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        // A response arriving with a timeout in the same cycle still wins.
        if (strobe_in) begin
          w_resp_nxt  = cmd_in[RESP_W-1:8];
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK_RESP;
        end else if (TIMEOUT_ENABLE && TIMEOUT) begin
          w_to_err_nxt   = 1'b1;
          w_complete_nxt = 1'b1;
          w_state_nxt    = DONE;
        end
      end

      ACK_RESP: begin
        if (!strobe_in) begin
          w_complete_nxt = 1'b1;
          w_state_nxt    = DONE;
        end else begin
          w_ack_nxt = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_host_ctrl.sv
// Directed testbench for sd_cmd_host_ctrl: reset, command issue, response
// capture, timeout, disabled timeout, reset abort and ignored requests.
module tb_sd_cmd_host_ctrl;

  logic         clock;
  logic         reset;
  logic         new_command;
  logic [31:0]  cmd_argument;
  logic [5:0]   cmd_index;
  logic         TIMEOUT_ENABLE;
  logic         TIMEOUT;
  logic         ack_in;
  logic         strobe_in;
  logic [135:0] cmd_in;
  logic         strobe_out;
  logic         ack_out;
  logic [39:0]  cmd_out;
  logic [127:0] response;
  logic         cmd_complete;
  logic         timeout_error;

  int n_checks;
  int n_errors;

  sd_cmd_host_ctrl #(.CMD_W(40), .RESP_W(136)) dut (
    .clock         (clock),
    .reset         (reset),
    .new_command   (new_command),
    .cmd_argument  (cmd_argument),
    .cmd_index     (cmd_index),
    .TIMEOUT_ENABLE(TIMEOUT_ENABLE),
    .TIMEOUT       (TIMEOUT),
    .ack_in        (ack_in),
    .strobe_in     (strobe_in),
    .cmd_in        (cmd_in),
    .strobe_out    (strobe_out),
    .ack_out       (ack_out),
    .cmd_out       (cmd_out),
    .response      (response),
    .cmd_complete  (cmd_complete),
    .timeout_error (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a command and walk the four-phase send handshake into WAIT_RESP.
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [39:0] exp_frame);
    cmd_index    = idx;
    cmd_argument = arg;
    new_command  = 1'b1;
    tick();
    new_command  = 1'b0;
    chk("issue_strobe_hi", 136'(strobe_out), 136'd1);
    chk("issue_frame", 136'(cmd_out), 136'(exp_frame));
    ack_in = 1'b1;
    tick();
    chk("ack_strobe_lo", 136'(strobe_out), 136'd0);
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b0;
    new_command    = 1'b0;
    cmd_argument   = '0;
    cmd_index      = '0;
    TIMEOUT_ENABLE = 1'b0;
    TIMEOUT        = 1'b0;
    ack_in         = 1'b0;
    strobe_in      = 1'b0;
    cmd_in         = '0;

    // Reset then idle
    repeat (3) tick();
    chk("rst_strobe", 136'(strobe_out), 136'd0);
    chk("rst_cmd_out", 136'(cmd_out), 136'd0);
    chk("rst_response", 136'(response), 136'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_strobe", 136'(strobe_out), 136'd0);
    chk("idle_ack", 136'(ack_out), 136'd0);
    chk("idle_complete", 136'(cmd_complete), 136'd0);
    chk("idle_to_err", 136'(timeout_error), 136'd0);

    // Command issue: strobe held while PHY has not acknowledged
    cmd_index    = 6'd7;
    cmd_argument = 32'd0;
    new_command  = 1'b1;
    tick();
    new_command  = 1'b0;
    chk("cmd7_strobe", 136'(strobe_out), 136'd1);
    chk("cmd7_frame", 136'(cmd_out), 136'(40'h47_0000_0000));
    tick();
    chk("cmd7_strobe_held", 136'(strobe_out), 136'd1);
    ack_in = 1'b1;
    tick();
    chk("cmd7_strobe_drop", 136'(strobe_out), 136'd0);
    tick();
    ack_in = 1'b0;
    tick();
    chk("cmd7_waitresp_noack", 136'(ack_out), 136'd0);

    // Response capture
    cmd_in    = {2'b00, 6'd7, 32'd789, 96'h0};
    strobe_in = 1'b1;
    tick();
    chk("resp_ack_hi", 136'(ack_out), 136'd1);
    chk("resp_payload", 136'(response), 136'(128'h07_00000315_0000000000000000000000));
    tick();
    chk("resp_ack_held", 136'(ack_out), 136'd1);
    chk("resp_no_complete", 136'(cmd_complete), 136'd0);
    strobe_in = 1'b0;
    tick();
    chk("resp_ack_lo", 136'(ack_out), 136'd0);
    chk("resp_complete", 136'(cmd_complete), 136'd1);
    chk("resp_to_err", 136'(timeout_error), 136'd0);
    tick();
    chk("resp_complete_pulse", 136'(cmd_complete), 136'd0);
    chk("resp_cmd_out_kept", 136'(cmd_out), 136'(40'h47_0000_0000));

    // Timeout with enable
    issue(6'd2, 32'hDEADBEEF, 40'h42_DEAD_BEEF);
    TIMEOUT_ENABLE = 1'b1;
    TIMEOUT        = 1'b1;
    tick();
    TIMEOUT        = 1'b0;
    chk("to_err_set", 136'(timeout_error), 136'd1);
    chk("to_complete", 136'(cmd_complete), 136'd1);
    chk("to_no_ack", 136'(ack_out), 136'd0);
    tick();
    chk("to_complete_pulse", 136'(cmd_complete), 136'd0);
    chk("to_err_sticky", 136'(timeout_error), 136'd1);
    chk("to_idle_strobe", 136'(strobe_out), 136'd0);

    // Next command clears the sticky error; timeout disabled waits forever
    TIMEOUT_ENABLE = 1'b0;
    cmd_index      = 6'd3;
    cmd_argument   = 32'd1;
    new_command    = 1'b1;
    tick();
    new_command    = 1'b0;
    chk("clr_to_err", 136'(timeout_error), 136'd0);
    chk("clr_frame", 136'(cmd_out), 136'(40'h43_0000_0001));
    ack_in = 1'b1;
    tick();
    tick();
    ack_in = 1'b0;
    tick();
    TIMEOUT = 1'b1;
    repeat (3) tick();
    chk("todis_no_complete", 136'(cmd_complete), 136'd0);
    chk("todis_no_err", 136'(timeout_error), 136'd0);

    // new_command while waiting for the response is ignored
    cmd_index    = 6'd9;
    cmd_argument = 32'h1234_5678;
    new_command  = 1'b1;
    tick();
    new_command  = 1'b0;
    chk("ign_cmd_out", 136'(cmd_out), 136'(40'h43_0000_0001));
    chk("ign_strobe", 136'(strobe_out), 136'd0);

    // Response and enabled timeout in the same cycle: response wins
    TIMEOUT_ENABLE = 1'b1;
    cmd_in    = 136'h01_23456789ABCDEF_FEDCBA9876543210_5A;
    strobe_in = 1'b1;
    tick();
    TIMEOUT        = 1'b0;
    TIMEOUT_ENABLE = 1'b0;
    chk("prio_ack", 136'(ack_out), 136'd1);
    chk("prio_no_err", 136'(timeout_error), 136'd0);
    chk("prio_payload", 136'(response), 136'(128'h0123456789ABCDEF_FEDCBA9876543210));
    strobe_in = 1'b0;
    tick();
    chk("prio_complete", 136'(cmd_complete), 136'd1);
    tick();

    // Asynchronous reset aborts an in-flight send
    cmd_index    = 6'd5;
    cmd_argument = 32'hA5A5_A5A5;
    new_command  = 1'b1;
    tick();
    new_command  = 1'b0;
    chk("abort_pre_strobe", 136'(strobe_out), 136'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_strobe", 136'(strobe_out), 136'd0);
    chk("abort_cmd_out", 136'(cmd_out), 136'd0);
    chk("abort_response", 136'(response), 136'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("abort_idle_strobe", 136'(strobe_out), 136'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_host_ctrl.md
Name: sd_cmd_host_ctrl

Overview:
Host-side SD command controller. It sits between the register/host logic (new_command, index, argument) and the command physical layer (cmd_phys). It builds the 40-bit command frame and hands it to the PHY with a four-phase strobe/ack handshake. It then waits for the PHY's response frame (or a timeout), latches it and acknowledges it.

Parameters:
CMD_W, 40, width of the command frame sent to the PHY.
RESP_W, 136, width of the response frame received from the PHY.

Ports:
clock  in  1  single system clock (sd_clock domain); all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
new_command  in  1  request to issue a command; sampled only in IDLE.
cmd_argument  in  32  command argument.
cmd_index  in  6  command index.
TIMEOUT_ENABLE  in  1  1 = TIMEOUT may abort the wait for a response.
TIMEOUT  in  1  timeout indication from an external timer.
ack_in  in  1  PHY acknowledges cmd_out/strobe_out.
strobe_in  in  1  PHY signals a valid response on cmd_in.
cmd_in  in  RESP_W  response frame from PHY.
strobe_out  out  1  command valid to PHY.
ack_out  out  1  acknowledge of response to PHY.
cmd_out  out  CMD_W  command frame to PHY.
response  out  128  latched response payload, cmd_in[135:8].
cmd_complete  out  1  one-cycle pulse when a command finishes, with or without error.
timeout_error  out  1  sticky error flag; set on timeout, cleared at next accepted new_command.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; strobe_out=0, ack_out=0, cmd_out=0, response=0, cmd_complete=0, timeout_error=0.
- Frame format: cmd_out = {1'b0 start, 1'b1 host-transmission, cmd_index, cmd_argument}, MSB first.
- Frame capture: cmd_out is registered when the request is accepted and held stable until return to IDLE.
- IDLE:
  - On new_command=1: latch cmd_out, clear timeout_error, go to SEND.
  - Otherwise all outputs hold and strobe_out/ack_out stay 0.
- SEND:
  - strobe_out=1.
  - When ack_in=1, drop strobe_out and go to WAIT_ACK_LOW.
- WAIT_ACK_LOW:
  - strobe_out=0; wait for ack_in=0 (four-phase completion).
  - Then go to WAIT_RESP.
- WAIT_RESP:
  - If strobe_in=1: latch response<=cmd_in[135:8], set ack_out=1, go to ACK_RESP.
  - Else if TIMEOUT_ENABLE=1 and TIMEOUT=1: set timeout_error=1, go to DONE.
  - strobe_in has priority when both strobe_in and a timeout occur in the same cycle.
  - TIMEOUT is ignored when TIMEOUT_ENABLE=0; the controller waits indefinitely.
- ACK_RESP:
  - Hold ack_out=1 until strobe_in=0.
  - Then ack_out<=0, go to DONE.
- DONE: cmd_complete=1 for exactly one cycle, then IDLE.
- Latencies:
  - new_command to strobe_out high: 1 clock.
  - ack_in high to strobe_out low: 1 clock.
  - strobe_in to ack_out: 1 clock.
- new_command asserted outside IDLE is ignored (not queued).
- A new command may start in the cycle after DONE.
- Asserting reset in any state aborts immediately to IDLE with reset output values. In-flight handshakes are dropped; the PHY must tolerate strobe_out/ack_out falling without completion.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then 1 with new_command=0 -> all outputs 0, state IDLE, no strobe.
- Command issue: cmd_index=7, cmd_argument=0, pulse new_command.
  - -> cmd_out=40'h47_0000_0000 and strobe_out=1 next cycle.
  - Return ack_in=1 -> strobe_out=0 next cycle.
  - Drop ack_in -> WAIT_RESP.
- Response capture: in WAIT_RESP drive cmd_in={2'b00,6'd7,32'd789,96'h0} with strobe_in=1.
  - -> ack_out=1 after 1 cycle; response=cmd_in[135:8].
  - Drop strobe_in -> ack_out=0, cmd_complete pulses one cycle, timeout_error=0.
- Timeout: TIMEOUT_ENABLE=1, no strobe_in, TIMEOUT=1 in WAIT_RESP -> timeout_error=1, cmd_complete pulse, return to IDLE; next new_command clears timeout_error.
- Timeout disabled: TIMEOUT_ENABLE=0, TIMEOUT=1 -> remains in WAIT_RESP; later strobe_in completes normally.
- Abort and ignore:
  - reset=0 while strobe_out=1 -> strobe_out=0 immediately.
  - new_command pulses during WAIT_RESP -> ignored; cmd_out unchanged.
